// File: rtl/mpsoc_riscv_ahb3_pkg.sv
// Shared AHB3-Lite constants, arbiter state encodings and the captured-request
// record used when replaying master address phases to the external slave.
package mpsoc_riscv_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Address field sized for the widest supported PLEN; narrower buses zero-extend.
  localparam int AHB3_ADDR_MAX = 64;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_ADDR = 2'd1;
  localparam logic [1:0] ARB_DATA = 2'd2;

  typedef struct packed {
    logic [AHB3_ADDR_MAX-1:0] addr;
    logic                     write;
    logic [2:0]               size;
    logic [2:0]               burst;
    logic [3:0]               prot;
    logic                     lock;
  } ahb3_req_t;

  function automatic logic htrans_is_xfer(input logic [1:0] htrans);
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mpsoc_riscv_rr_arbiter.sv
// Round-robin grant over a request vector, searching from ptr_i with wrap-around.
// A valid lock holder overrides the search and is the only master that may win.
module mpsoc_riscv_rr_arbiter #(
  parameter int NODES = 16,
  parameter int IW    = (NODES > 1) ? $clog2(NODES) : 1
) (
  input  logic [NODES-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  input  logic             lock_v_i,
  input  logic [IW-1:0]    lock_id_i,
  output logic             gnt_v_o,
  output logic [IW-1:0]    gnt_id_o
);

  int          idx;
  logic [IW-1:0] sel;

  always_comb begin
    gnt_v_o  = 1'b0;
    gnt_id_o = '0;
    idx      = 0;
    sel      = '0;
    if (lock_v_i) begin
      gnt_v_o  = req_i[lock_id_i];
      gnt_id_o = lock_id_i;
    end else begin
      // Walk offsets far-to-near so the nearest request at/after ptr_i wins last.
      for (int k = NODES - 1; k >= 0; k--) begin
        idx = int'(ptr_i) + k;
        if (idx >= NODES) idx = idx - NODES;
        sel = IW'(idx);
        if (req_i[sel]) begin
          gnt_v_o  = 1'b1;
          gnt_id_o = sel;
        end
      end
    end
  end

endmodule

// File: rtl/mpsoc_riscv_ahb3_ext_arbiter.sv
// Merges NODES AHB3-Lite master ports onto one external slave: each accepted
// address phase is parked per master and replayed one at a time, round-robin.
//
// state | meaning
// IDLE  | no slave transfer; pick a winner among pending masters
// ADDR  | replay winner's address phase (NONSEQ) to the slave
// DATA  | slave data phase; winner's HREADY follows slave HREADY
module mpsoc_riscv_ahb3_ext_arbiter
  import mpsoc_riscv_ahb3_pkg::*;
#(
  parameter int PLEN  = 32,
  parameter int XLEN  = 32,
  parameter int NODES = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [NODES-1:0]      mst_hsel,
  input  logic [NODES*PLEN-1:0] mst_haddr,
  input  logic [NODES*XLEN-1:0] mst_hwdata,
  input  logic [NODES-1:0]      mst_hwrite,
  input  logic [NODES*3-1:0]    mst_hsize,
  input  logic [NODES*3-1:0]    mst_hburst,
  input  logic [NODES*4-1:0]    mst_hprot,
  input  logic [NODES*2-1:0]    mst_htrans,
  input  logic [NODES-1:0]      mst_hmastlock,
  output logic [NODES*XLEN-1:0] mst_hrdata,
  output logic [NODES-1:0]      mst_hready,
  output logic [NODES-1:0]      mst_hresp,

  output logic                  slv_hsel,
  output logic [PLEN-1:0]       slv_haddr,
  output logic [XLEN-1:0]       slv_hwdata,
  output logic                  slv_hwrite,
  output logic [2:0]            slv_hsize,
  output logic [2:0]            slv_hburst,
  output logic [3:0]            slv_hprot,
  output logic [1:0]            slv_htrans,
  output logic                  slv_hmastlock,
  input  logic [XLEN-1:0]       slv_hrdata,
  input  logic                  slv_hready,
  input  logic                  slv_hresp
);

  localparam int IW = (NODES > 1) ? $clog2(NODES) : 1;

  ahb3_req_t        pend_q [NODES];
  ahb3_req_t        pend_d [NODES];
  logic [NODES-1:0] pend_v_q, pend_v_d;
  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    g_q, g_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic             lock_v_q, lock_v_d;
  logic [IW-1:0]    lock_id_q, lock_id_d;

  logic             gnt_v;
  logic [IW-1:0]    gnt_id;
  logic [NODES-1:0] acc;

  mpsoc_riscv_rr_arbiter #(
    .NODES (NODES),
    .IW    (IW)
  ) u_rr_arbiter (
    .req_i     (pend_v_q),
    .ptr_i     (rr_q),
    .lock_v_i  (lock_v_q),
    .lock_id_i (lock_id_q),
    .gnt_v_o   (gnt_v),
    .gnt_id_o  (gnt_id)
  );

  // Master-side response: parked masters stall until their replay completes.
  always_comb begin
    mst_hready = ~pend_v_q;
    mst_hresp  = {NODES{HRESP_OKAY}};
    mst_hrdata = '0;
    if (state_q == ARB_DATA) begin
      mst_hrdata[g_q*XLEN +: XLEN] = slv_hrdata;
      mst_hresp[g_q]               = slv_hresp;
      if (slv_hready) mst_hready[g_q] = 1'b1;
    end
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < NODES; i++) begin
      acc[i] = mst_hready[i] & mst_hsel[i] & htrans_is_xfer(mst_htrans[2*i +: 2]);
    end
  end

  always_comb begin
    slv_hsel      = 1'b0;
    slv_htrans    = HTRANS_IDLE;
    slv_haddr     = '0;
    slv_hwrite    = 1'b0;
    slv_hsize     = '0;
    slv_hburst    = '0;
    slv_hprot     = '0;
    slv_hmastlock = 1'b0;
    slv_hwdata    = '0;
    case (state_q)
      ARB_ADDR: begin
        slv_hsel      = 1'b1;
        slv_htrans    = HTRANS_NONSEQ;
        slv_haddr     = pend_q[g_q].addr[PLEN-1:0];
        slv_hwrite    = pend_q[g_q].write;
        slv_hsize     = pend_q[g_q].size;
        slv_hburst    = pend_q[g_q].burst;
        slv_hprot     = pend_q[g_q].prot;
        slv_hmastlock = pend_q[g_q].lock;
      end
      ARB_DATA: slv_hwdata = mst_hwdata[g_q*XLEN +: XLEN];
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    rr_d      = rr_q;
    lock_v_d  = lock_v_q;
    lock_id_d = lock_id_q;
    pend_v_d  = pend_v_q;
    pend_d    = pend_q;

    case (state_q)
      ARB_IDLE: begin
        if (gnt_v) begin
          g_d     = gnt_id;
          state_d = ARB_ADDR;
        end
      end
      ARB_ADDR: state_d = ARB_DATA;
      ARB_DATA: begin
        if (slv_hready) begin
          pend_v_d[g_q] = 1'b0;
          rr_d          = (int'(g_q) == NODES - 1) ? '0 : g_q + 1'b1;
          if (pend_q[g_q].lock) begin
            lock_v_d  = 1'b1;
            lock_id_d = g_q;
          end else if (lock_v_q && (lock_id_q == g_q)) begin
            lock_v_d  = 1'b0;
          end
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // Capture after completion so a back-to-back request from the winner survives.
    for (int i = 0; i < NODES; i++) begin
      if (acc[i]) begin
        pend_v_d[i]              = 1'b1;
        pend_d[i]                = '0;
        pend_d[i].addr[PLEN-1:0] = mst_haddr[i*PLEN +: PLEN];
        pend_d[i].write          = mst_hwrite[i];
        pend_d[i].size           = mst_hsize[3*i +: 3];
        pend_d[i].burst          = mst_hburst[3*i +: 3];
        pend_d[i].prot           = mst_hprot[4*i +: 4];
        pend_d[i].lock           = mst_hmastlock[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      g_q       <= '0;
      rr_q      <= '0;
      lock_v_q  <= 1'b0;
      lock_id_q <= '0;
      pend_v_q  <= '0;
      for (int i = 0; i < NODES; i++) pend_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      rr_q      <= rr_d;
      lock_v_q  <= lock_v_d;
      lock_id_q <= lock_id_d;
      pend_v_q  <= pend_v_d;
      for (int i = 0; i < NODES; i++) pend_q[i] <= pend_d[i];
    end
  end

endmodule

// File: tb/tb_mpsoc_riscv_ahb3_ext_arbiter.sv
// Bench for the external AHB3 arbiter: cycle-stepped master and slave models with
// an expected-transfer queue checked on slave replay and on master release.
module tb_mpsoc_riscv_ahb3_ext_arbiter;
  import mpsoc_riscv_ahb3_pkg::*;

  localparam int NODES = 16;
  localparam int PLEN  = 32;
  localparam int XLEN  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NODES-1:0]      mst_hsel, mst_hwrite, mst_hmastlock;
  logic [NODES*PLEN-1:0] mst_haddr;
  logic [NODES*XLEN-1:0] mst_hwdata;
  logic [NODES*3-1:0]    mst_hsize, mst_hburst;
  logic [NODES*4-1:0]    mst_hprot;
  logic [NODES*2-1:0]    mst_htrans;
  logic [NODES*XLEN-1:0] mst_hrdata;
  logic [NODES-1:0]      mst_hready, mst_hresp;
  logic                  slv_hsel, slv_hwrite, slv_hmastlock;
  logic [PLEN-1:0]       slv_haddr;
  logic [XLEN-1:0]       slv_hwdata;
  logic [2:0]            slv_hsize, slv_hburst;
  logic [3:0]            slv_hprot;
  logic [1:0]            slv_htrans;
  logic [XLEN-1:0]       slv_hrdata;
  logic                  slv_hready, slv_hresp;

  mpsoc_riscv_ahb3_ext_arbiter #(.PLEN(PLEN), .XLEN(XLEN), .NODES(NODES)) dut (
    .clk(clk), .rst(rst),
    .mst_hsel(mst_hsel), .mst_haddr(mst_haddr), .mst_hwdata(mst_hwdata),
    .mst_hwrite(mst_hwrite), .mst_hsize(mst_hsize), .mst_hburst(mst_hburst),
    .mst_hprot(mst_hprot), .mst_htrans(mst_htrans), .mst_hmastlock(mst_hmastlock),
    .mst_hrdata(mst_hrdata), .mst_hready(mst_hready), .mst_hresp(mst_hresp),
    .slv_hsel(slv_hsel), .slv_haddr(slv_haddr), .slv_hwdata(slv_hwdata),
    .slv_hwrite(slv_hwrite), .slv_hsize(slv_hsize), .slv_hburst(slv_hburst),
    .slv_hprot(slv_hprot), .slv_htrans(slv_htrans), .slv_hmastlock(slv_hmastlock),
    .slv_hrdata(slv_hrdata), .slv_hready(slv_hready), .slv_hresp(slv_hresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic        lock;
    int          waits;
    logic        err;
    logic [31:0] rdata;
    int          exp_wait;
  } txn_t;

  txn_t stim_q[$];
  txn_t exp_q[$];

  bit   act[NODES];
  bit   dph[NODES];
  txn_t cur_a[NODES];
  txn_t cur_d[NODES];
  int   wcnt[NODES];
  bit   serr[NODES];
  bit   acc_s[NODES];
  bit   done_s[NODES];

  bit   sd_act, sd_eph, snonseq, sdone;
  txn_t sd_cur;
  int   sd_cnt;
  int   nonseq_cnt = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input int m, input logic [31:0] addr, input logic wr,
                       input logic [31:0] wdata, input logic lock, input int waits,
                       input logic err, input logic [31:0] rdata, input int ew);
    txn_t t;
    t.m = m; t.addr = addr; t.wr = wr; t.wdata = wdata; t.lock = lock;
    t.waits = waits; t.err = err; t.rdata = rdata; t.exp_wait = ew;
    stim_q.push_back(t);
    exp_q.push_back(t);
  endtask

  task automatic drive();
    for (int i = 0; i < NODES; i++) begin
      mst_hsel[i]             = act[i];
      mst_htrans[2*i +: 2]    = act[i] ? HTRANS_NONSEQ : HTRANS_IDLE;
      mst_haddr[i*PLEN +: PLEN] = act[i] ? cur_a[i].addr : 32'h0;
      mst_hwrite[i]           = act[i] ? cur_a[i].wr : 1'b0;
      mst_hmastlock[i]        = act[i] ? cur_a[i].lock : 1'b0;
      mst_hsize[3*i +: 3]     = 3'b010;
      mst_hburst[3*i +: 3]    = 3'b001;
      mst_hprot[4*i +: 4]     = 4'b0011;
      mst_hwdata[i*XLEN +: XLEN] = dph[i] ? cur_d[i].wdata : 32'h0;
    end
    if (sd_act) begin
      slv_hrdata = sd_cur.rdata;
      if (sd_cnt > 0) begin
        slv_hready = 1'b0; slv_hresp = HRESP_OKAY; sd_cnt--;
      end else if (sd_cur.err && !sd_eph) begin
        slv_hready = 1'b0; slv_hresp = HRESP_ERROR; sd_eph = 1'b1;
      end else begin
        slv_hready = 1'b1; slv_hresp = sd_cur.err;
      end
    end else begin
      slv_hrdata = 32'h0; slv_hready = 1'b1; slv_hresp = HRESP_OKAY;
    end
  endtask

  // Sampled at the falling edge, with all bench inputs settled since #1 after rise.
  task automatic monitor();
    snonseq = slv_hsel && (slv_htrans == HTRANS_NONSEQ);
    if (snonseq) begin
      nonseq_cnt++;
      chk("slv_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        sd_cur = exp_q.pop_front();
        chk("slv_haddr", slv_haddr, sd_cur.addr);
        chk("slv_hwrite", slv_hwrite, sd_cur.wr);
        chk("slv_hmastlock", slv_hmastlock, sd_cur.lock);
        chk("slv_hsize", slv_hsize, 3'b010);
        chk("slv_hburst", slv_hburst, 3'b001);
        chk("slv_hprot", slv_hprot, 4'b0011);
      end
    end
    sdone = sd_act && slv_hready;
    if (sdone && sd_cur.wr) chk("slv_hwdata", slv_hwdata, sd_cur.wdata);
    for (int i = 0; i < NODES; i++) begin
      done_s[i] = dph[i] && mst_hready[i];
      acc_s[i]  = act[i] && mst_hready[i];
      if (dph[i]) begin
        if (mst_hready[i]) begin
          chk("done_master", i, sd_cur.m);
          chk("mst_hresp", mst_hresp[i], cur_d[i].err);
          chk("err_phase", serr[i], cur_d[i].err);
          if (!cur_d[i].wr) chk("mst_hrdata", mst_hrdata[i*XLEN +: XLEN], cur_d[i].rdata);
          if (cur_d[i].exp_wait >= 0) chk("wait_states", wcnt[i], cur_d[i].exp_wait);
        end else begin
          wcnt[i]++;
          if (mst_hresp[i]) serr[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic update();
    if (sdone) sd_act = 1'b0;
    if (snonseq) begin
      sd_act = 1'b1; sd_cnt = sd_cur.waits; sd_eph = 1'b0;
    end
    for (int i = 0; i < NODES; i++) begin
      if (done_s[i]) dph[i] = 1'b0;
      if (acc_s[i]) begin
        dph[i] = 1'b1; cur_d[i] = cur_a[i]; wcnt[i] = 0; serr[i] = 1'b0; act[i] = 1'b0;
      end
      if (!act[i]) begin
        for (int k = 0; k < stim_q.size(); k++) begin
          if (stim_q[k].m == i) begin
            cur_a[i] = stim_q[k];
            stim_q.delete(k);
            act[i] = 1'b1;
            break;
          end
        end
      end
    end
    drive();
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    update();
  endtask

  function automatic bit busy();
    bit b = sd_act || (stim_q.size() != 0) || (exp_q.size() != 0);
    for (int i = 0; i < NODES; i++) b = b || act[i] || dph[i];
    return b;
  endfunction

  task automatic drain(input string tag, input int max);
    int n = 0;
    while (busy() && n < max) begin
      step();
      n++;
    end
    chk(tag, n < max, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1);
  end

  initial begin
    int n, n0;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hready", mst_hready, {NODES{1'b1}});
    chk("rst_hresp", mst_hresp, 0);
    chk("rst_hrdata", |mst_hrdata, 0);
    chk("rst_slv_hsel", slv_hsel, 0);
    chk("rst_slv_htrans", slv_htrans, HTRANS_IDLE);
    chk("rst_slv_haddr", slv_haddr, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Contention with pointer at 0: order 0,1,5.
    issue(0, 32'h1000_0000, 1'b1, 32'hA0A0_0000, 1'b0, 0, 1'b0, 32'h0, 2);
    issue(1, 32'h1000_0004, 1'b0, 32'h0,         1'b0, 0, 1'b0, 32'h1111_2222, 5);
    issue(5, 32'h1000_0014, 1'b1, 32'h5555_0005, 1'b0, 0, 1'b0, 32'h0, 8);
    drain("drain_contention", 100);

    // Pointer now 6: master 7 must beat master 4.
    issue(7, 32'h2000_0070, 1'b1, 32'h7777_0007, 1'b0, 0, 1'b0, 32'h0, 2);
    issue(4, 32'h2000_0040, 1'b0, 32'h0,         1'b0, 0, 1'b0, 32'h4444_0004, 5);
    drain("drain_pointer", 100);

    issue(3, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 32'h0, 2);
    drain("drain_single", 100);

    issue(7, 32'h8000_0100, 1'b0, 32'h0, 1'b0, 4, 1'b0, 32'h1234_5678, 6);
    drain("drain_waits", 100);

    issue(9, 32'h8000_0200, 1'b0, 32'h0, 1'b0, 0, 1'b1, 32'hEEEE_0009, 3);
    drain("drain_error", 100);
    chk("err_pend_clr", mst_hready[9], 1);

    // Lock: master 4 arrives behind master 2's locked sequence.
    issue(2, 32'h3000_0000, 1'b1, 32'h2222_0001, 1'b1, 0, 1'b0, 32'h0, 2);
    step();
    issue(2, 32'h3000_0004, 1'b1, 32'h2222_0002, 1'b1, 0, 1'b0, 32'h0, 2);
    issue(2, 32'h3000_0008, 1'b0, 32'h0,         1'b0, 0, 1'b0, 32'h2222_0003, 2);
    issue(4, 32'h4000_0000, 1'b1, 32'h4444_0044, 1'b0, 0, 1'b0, 32'h0, -1);
    drain("drain_lock", 200);

    // Reset while a transfer is in its data phase and two more are parked.
    issue(10, 32'h5000_0000, 1'b1, 32'hAAAA_000A, 1'b0, 3, 1'b0, 32'h0, -1);
    issue(11, 32'h5000_0004, 1'b1, 32'hAAAA_000B, 1'b0, 3, 1'b0, 32'h0, -1);
    issue(12, 32'h5000_0008, 1'b1, 32'hAAAA_000C, 1'b0, 3, 1'b0, 32'h0, -1);
    n = 0;
    while (!sd_act && n < 20) begin
      step();
      n++;
    end
    chk("reach_data", sd_act, 1);
    rst = 1'b1;
    stim_q.delete();
    exp_q.delete();
    for (int i = 0; i < NODES; i++) begin
      act[i] = 1'b0; dph[i] = 1'b0;
    end
    sd_act = 1'b0;
    drive();
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rstmid_hready", mst_hready, {NODES{1'b1}});
    chk("rstmid_htrans", slv_htrans, HTRANS_IDLE);
    chk("rstmid_hsel", slv_hsel, 0);
    n0 = nonseq_cnt;
    repeat (10) step();
    chk("rstmid_no_req", nonseq_cnt - n0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mpsoc_riscv_ahb3_ext_arbiter.md
Name: mpsoc_riscv_ahb3_ext_arbiter

Overview:
- Downstream consumer of the per-tile AHB3-Lite external master ports of the multi-dimensional mesh MPSoC.
- Merges NODES master ports onto one shared external AHB3-Lite slave, e.g. off-chip memory controller.
- Each accepted master address phase is captured in a per-master pending register and replayed to the slave under round-robin arbitration.
- The master's data phase is stretched with HREADY low until the replayed transfer completes.

Parameters:
- PLEN, 32, address width.
- XLEN, 32, data width.
- NODES, 16, number of master ports (X*Y*Z*T at top level).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- mst_hsel  in  NODES  per-master select.
- mst_haddr  in  NODES*PLEN  per-master address.
- mst_hwdata  in  NODES*XLEN  per-master write data.
- mst_hwrite  in  NODES  per-master write flag.
- mst_hsize  in  NODES*3  per-master transfer size.
- mst_hburst  in  NODES*3  per-master burst type.
- mst_hprot  in  NODES*4  per-master protection.
- mst_htrans  in  NODES*2  per-master transfer type.
- mst_hmastlock  in  NODES  per-master lock request.
- mst_hrdata  out  NODES*XLEN  read data to each master.
- mst_hready  out  NODES  ready to each master.
- mst_hresp  out  NODES  response to each master (1 = ERROR).
- slv_hsel, slv_haddr, slv_hwdata, slv_hwrite, slv_hsize, slv_hburst, slv_hprot, slv_htrans, slv_hmastlock  out  AHB widths as above  shared slave request.
- slv_hrdata  in  XLEN  slave read data.
- slv_hready  in  1  slave ready.
- slv_hresp  in  1  slave response.

Behaviour:
- Reset (rst=1 at a clk edge) values:
  - pend_v all 0; FSM in IDLE; RR pointer 0; lock owner cleared.
  - mst_hready all 1; mst_hresp 0; mst_hrdata 0.
  - slv_hsel 0; slv_htrans 2'b00; all other slv_* outputs 0.
  - Reset mid-transfer abandons the slave transfer and discards all pending requests.
- Capture:
  - Master i's address phase is accepted when mst_hready[i]=1, mst_hsel[i]=1 and mst_htrans[i] is NONSEQ(10) or SEQ(11).
  - haddr, hwrite, hsize, hburst, hprot, hmastlock are registered into pend[i]; pend_v[i] is set.
  - From the next cycle mst_hready[i]=0 until completion.
  - IDLE(00) and BUSY(01) transfers are never captured and need no response beyond hready=1, hresp=0.
- FSM states: IDLE, ADDR, DATA.
  - IDLE: if any pend_v is set, select the winner g. If the lock owner is valid, g = lock owner; otherwise g = first pending index at or after the RR pointer, with wrap-around. Go to ADDR.
  - ADDR (exactly 1 cycle): slv_hsel=1, slv_htrans=NONSEQ, remaining slv_* = pend[g] fields. Go to DATA.
  - DATA:
    - slv_htrans=IDLE; slv_hwdata = mst_hwdata[g] (the master holds write data while stalled); mst_hrdata[g] = slv_hrdata.
    - When slv_hready=1: mst_hready[g]=1 and mst_hresp[g]=slv_hresp, combinational in that cycle; clear pend_v[g]; RR pointer = g+1 mod NODES; go to IDLE.
    - Two-cycle ERROR: while slv_hresp=1 and slv_hready=0, drive mst_hresp[g]=1 with mst_hready[g]=0.
- Throughput: one outstanding slave transfer; minimum 3 cycles per transfer. Uncontended master sees 2 wait states with a zero-wait slave.
- Lock:
  - Completion of a transfer with captured hmastlock=1 sets lock owner = g.
  - Completion with hmastlock=0 from the owner clears it.
  - While the lock is held, other pending masters wait.
- A new request from the completing master in its completion cycle (hready=1) is captured normally. A simultaneous set and clear of pend_v[g] resolves to set.
- slv_hburst is replayed as captured. Bursts are issued as independent single transfers with NONSEQ; the slave must tolerate this.

Decomposition:
- Shared package mpsoc_riscv_ahb3_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ constants, HRESP_OKAY/ERROR, ahb3_req_t struct (addr, write, size, burst, prot, lock).
- Sub-module mpsoc_riscv_rr_arbiter: NODES-wide round-robin grant from a request vector and pointer, with a lock override.

Test Plan:
- Single write: master 3 issues NONSEQ write 0x8000_0010, data 0xDEADBEEF, slv_hready=1 → slave sees NONSEQ 0x8000_0010 one cycle after capture, hwdata 0xDEADBEEF next cycle; mst_hready[3] low 2 cycles, then 1 with hresp 0.
- Contention: masters 0, 1, 5 request in the same cycle, RR pointer 0 → slave order 0, 1, 5; each master released in turn; pointer ends at 6.
- Wait states: slave holds hready=0 for 4 cycles on a read returning 0x1234_5678 → mst_hready[g] low 6 cycles; mst_hrdata[g]=0x1234_5678 on the release cycle.
- Error: slave returns hresp=1 with hready 0 then 1 → master sees hresp=1/hready=0, then hresp=1/hready=1; pend_v cleared.
- Lock: master 2 issues 2 locked transfers then 1 unlocked; master 4 is pending throughout → master 4 is served only after master 2's unlocked transfer completes.
- Reset mid-DATA: assert rst during DATA with 3 pending requests → next cycle all mst_hready=1, slv_htrans=00, no further slave requests.
